// File: rtl/sid_dac_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sid_dac_pkg - request kinds, scale and 6581 per-bit DAC weights. Rev 1.0
// ----------------------------------------------------------------------------
package sid_dac_pkg;

  typedef enum logic [1:0] {
    DAC_WAVE   = 2'd0,
    DAC_ENV    = 2'd1,
    DAC_CUTOFF = 2'd2,
    DAC_INV    = 2'd3
  } dac_kind_t;

  localparam int SCALEBITS = 4;
  localparam int ACC_W     = 16;

  // Packed tables: element [n] is the weight of input bit n.
  localparam logic [11:0][15:0] W_WAVE = {
    16'h7bed, 16'h3fec, 16'h20f8, 16'h1102, 16'h08c6, 16'h0486,
    16'h0256, 16'h0135, 16'h00a0, 16'h0055, 16'h0030, 16'h0021
  };
  localparam logic [7:0][15:0] W_ENV = {
    16'h07b8, 16'h03fb, 16'h020e, 16'h0110,
    16'h008d, 16'h004b, 16'h002a, 16'h001d
  };
  localparam logic [10:0][15:0] W_CUTOFF = {
    16'h3df3, 16'h1ff4, 16'h107b, 16'h0880, 16'h0463, 16'h0243,
    16'h012b, 16'h009c, 16'h0052, 16'h002f, 16'h0020
  };

  function automatic logic [3:0] dac_nbits(input dac_kind_t kind);
    case (kind)
      DAC_WAVE:   return 4'd12;
      DAC_ENV:    return 4'd8;
      DAC_CUTOFF: return 4'd11;
      default:    return 4'd0;
    endcase
  endfunction

  // Ideal weights place each code bit exactly above the guard bits.
  function automatic logic [15:0] dac_weight(input dac_kind_t kind,
                                             input logic [3:0] bit_idx,
                                             input logic       ideal);
    logic [15:0] w;
    w = '0;
    if (ideal) begin
      w = 16'd1 << (5'(bit_idx) + 5'(SCALEBITS));
    end else begin
      case (kind)
        DAC_WAVE:   if (bit_idx < 4'd12) w = W_WAVE[bit_idx];
        DAC_ENV:    if (bit_idx < 4'd8)  w = W_ENV[bit_idx[2:0]];
        DAC_CUTOFF: if (bit_idx < 4'd11) w = W_CUTOFF[bit_idx];
        default:    w = '0;
      endcase
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sid_rr_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sid_rr_arb - combinational round-robin picker, search starts at ptr. Rev 1.0
// ----------------------------------------------------------------------------
module sid_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_idx,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    int cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt       = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sid_dac_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sid_dac_sched - round-robin scheduler around one bit-serial SID DAC
// accumulator. Optional 8580 ideal weights: SID_DAC_SCHED_8580_EN. Rev 1.0
// ----------------------------------------------------------------------------
module sid_dac_sched #(
  parameter  int NREQ      = 4,
  parameter  int SCALEBITS = 4,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][1:0] req_kind,
  input  logic [NREQ-1:0][11:0] req_val,
  output logic [NREQ-1:0]      req_ready,
`ifdef SID_DAC_SCHED_8580_EN
  input  logic                 model_8580,
`endif
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [1:0]           rsp_kind,
  output logic [11:0]          rsp_val,
  output logic                 busy
);

  import sid_dac_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] ACC_INIT = 16'(1 << (SCALEBITS - 1));

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  dac_kind_t      kind_q, kind_d;
  logic [11:0]    val_q, val_d;
  logic [15:0]    acc_q, acc_d;
  logic [3:0]     bit_q, bit_d;
  logic [3:0]     nbits_q, nbits_d;
  logic           ideal_q, ideal_d;

  logic            w_gnt_valid;
  logic [IDW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_gnt;
  logic            w_model_sel;

`ifdef SID_DAC_SCHED_8580_EN
  assign w_model_sel = model_8580;
`else
  assign w_model_sel = 1'b0;
`endif

  sid_rr_arb #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx),
    .gnt       (w_gnt)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    kind_d    = kind_q;
    val_d     = val_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    nbits_d   = nbits_q;
    ideal_d   = ideal_q;
    req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = w_gnt;
        if (w_gnt_valid) begin
          id_d     = w_gnt_idx;
          kind_d   = dac_kind_t'(req_kind[w_gnt_idx]);
          val_d    = req_val[w_gnt_idx];
          acc_d    = ACC_INIT;
          bit_d    = '0;
          nbits_d  = dac_nbits(kind_d);
          ideal_d  = w_model_sel;
          rr_ptr_d = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
          // Invalid kind has nothing to convert; report zero straight away.
          state_d  = (kind_d == DAC_INV) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (val_q[bit_q]) begin
          acc_d = acc_q + dac_weight(kind_q, bit_q, ideal_q);
        end
        bit_d = bit_q + 4'd1;
        if (bit_q == nbits_q - 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_val = '0;
    if (state_q == ST_DONE) begin
      case (nbits_q)
        4'd12:   rsp_val = acc_q[SCALEBITS +: 12];
        4'd8:    rsp_val = {4'b0, acc_q[SCALEBITS +: 8]};
        4'd11:   rsp_val = {1'b0, acc_q[SCALEBITS +: 11]};
        default: rsp_val = '0;
      endcase
    end
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = id_q;
  assign rsp_kind  = kind_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      kind_q   <= DAC_WAVE;
      val_q    <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      nbits_q  <= '0;
      ideal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      kind_q   <= kind_d;
      val_q    <= val_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      nbits_q  <= nbits_d;
      ideal_q  <= ideal_d;
    end
  end

endmodule
`default_nettype wire
